// File: rtl/corelet_pkg.sv
// Shared corelet constants, writer FSM state encoding and the saturating lane adder.
// Every block that touches partial sums uses this package so that the widths and rounding stay consistent.
package corelet_pkg;

  localparam int col     = 8;
  localparam int psum_bw = 16;
  localparam int addr_bw = 9;
  localparam int npix    = 16;
  localparam int idx_bw  = $clog2(npix);

  typedef enum logic [1:0] {IDLE, FETCH, ACCUM, DONE} state_t;

  // One guard bit catches overflow; clamp to the signed rails instead of wrapping.
  function automatic logic signed [psum_bw-1:0] sat_add(
    input logic signed [psum_bw-1:0] a,
    input logic signed [psum_bw-1:0] b
  );
    logic signed [psum_bw:0] s;
    s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    if (s[psum_bw] != s[psum_bw-1])
      sat_add = s[psum_bw] ? {1'b1, {(psum_bw-1){1'b0}}} : {1'b0, {(psum_bw-1){1'b1}}};
    else
      sat_add = s[psum_bw-1:0];
  endfunction

endpackage

// File: rtl/psum_lane_alu.sv
// Combinational lane datapath: saturating stored+new sum (or new sum alone on a
// first pass), followed by an optional ReLU applied to the saturated value.
module psum_lane_alu
  import corelet_pkg::*;
(
  input  logic signed [psum_bw-1:0] i_acc,
  input  logic signed [psum_bw-1:0] i_row,
  input  logic                      i_bypass,
  input  logic                      i_relu,
  output logic signed [psum_bw-1:0] o_res
);

  logic signed [psum_bw-1:0] w_sum;

  assign w_sum = i_bypass ? i_row : sat_add(i_acc, i_row);
  assign o_res = (i_relu && w_sum[psum_bw-1]) ? '0 : w_sum;

endmodule

// File: rtl/psum_accum_writer.sv
// Drains output-FIFO rows into PMEM: direct writes on the first kernel pass and
// read-modify-write on later passes, with an optional ReLU on the final pass.
module psum_accum_writer
  import corelet_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     first_pass,
  input  logic                     relu_en,
  input  logic [addr_bw-1:0]       base_addr,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  input  logic [col*psum_bw-1:0]   mem_q,
  output logic [col*psum_bw-1:0]   mem_d,
  output logic [addr_bw-1:0]       mem_addr,
  output logic                     mem_cen,
  output logic                     mem_wen,
  output logic                     busy,
  output logic                     done
);

  state_t                   r_state;
  logic [idx_bw-1:0]        r_idx;
  logic                     r_first;
  logic                     r_relu;
  logic                     r_busy;
  logic                     r_done;
  logic [addr_bw-1:0]       r_base;
  logic [addr_bw-1:0]       r_last_addr;
  logic [col*psum_bw-1:0]   r_row;

  logic                     w_fetch_go;
  logic                     w_last;
  logic                     w_rd_req;
  logic                     w_wr_req;
  logic                     w_access;
  logic [addr_bw-1:0]       w_addr;
  logic [col*psum_bw-1:0]   w_opnd;
  logic [col*psum_bw-1:0]   w_res;

  assign w_fetch_go = (r_state == FETCH) && ofifo_valid;
  assign w_last     = (r_idx == idx_bw'(npix - 1));
  assign w_rd_req   = w_fetch_go && !r_first;
  assign w_wr_req   = (w_fetch_go && r_first) || (r_state == ACCUM);
  assign w_access   = w_rd_req || w_wr_req;
  assign w_addr     = r_base + addr_bw'(r_idx);

  // ACCUM adds against the row captured at the read, not the live FIFO head.
  assign w_opnd = (r_state == ACCUM) ? r_row : ofifo_out;

  genvar g;
  generate
    for (g = 0; g < col; g++) begin : g_lane
      psum_lane_alu u_lane (
        .i_acc    (mem_q[g*psum_bw +: psum_bw]),
        .i_row    (w_opnd[g*psum_bw +: psum_bw]),
        .i_bypass (r_first),
        .i_relu   (r_relu),
        .o_res    (w_res[g*psum_bw +: psum_bw])
      );
    end
  endgenerate

  assign ofifo_rd = w_fetch_go;
  assign mem_cen  = !w_access;
  assign mem_wen  = !w_wr_req;
  assign mem_addr = w_access ? w_addr : r_last_addr;
  assign mem_d    = w_wr_req ? w_res : '0;
  assign busy     = r_busy;
  assign done     = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_first     <= 1'b0;
      r_relu      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_base      <= '0;
      r_last_addr <= '0;
      r_row       <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_access)
        r_last_addr <= w_addr;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_first <= first_pass;
            r_relu  <= relu_en;
            r_base  <= base_addr;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= FETCH;
          end
        end
        FETCH: begin
          if (ofifo_valid) begin
            if (r_first) begin
              r_idx <= r_idx + 1'b1;
              if (w_last) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end
            end else begin
              r_row   <= ofifo_out;
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          r_idx <= r_idx + 1'b1;
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= FETCH;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum_writer.sv
// Directed bench for psum_accum_writer with a show-ahead FIFO model and a
// single-port PMEM model (read data one cycle after the request).
module tb_psum_accum_writer;

  localparam int COL  = 8;
  localparam int BW   = 16;
  localparam int AW   = 9;
  localparam int NPIX = 16;
  localparam int W    = COL * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          first_pass;
  logic          relu_en;
  logic [AW-1:0] base_addr;
  logic          ofifo_valid;
  logic [W-1:0]  ofifo_out;
  logic          ofifo_rd;
  logic [W-1:0]  mem_q;
  logic [W-1:0]  mem_d;
  logic [AW-1:0] mem_addr;
  logic          mem_cen;
  logic          mem_wen;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psum_accum_writer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .first_pass  (first_pass),
    .relu_en     (relu_en),
    .base_addr   (base_addr),
    .ofifo_valid (ofifo_valid),
    .ofifo_out   (ofifo_out),
    .ofifo_rd    (ofifo_rd),
    .mem_q       (mem_q),
    .mem_d       (mem_d),
    .mem_addr    (mem_addr),
    .mem_cen     (mem_cen),
    .mem_wen     (mem_wen),
    .busy        (busy),
    .done        (done)
  );

  // Show-ahead FIFO: the task fills it, the DUT pops it.
  logic [W-1:0] fifo_mem [0:255];
  logic [7:0]   fifo_wr  = '0;
  logic [7:0]   fifo_rdp = '0;

  assign ofifo_valid = (fifo_rdp != fifo_wr);
  assign ofifo_out   = fifo_mem[fifo_rdp];

  always @(posedge clk)
    if (ofifo_rd && ofifo_valid) fifo_rdp <= fifo_rdp + 8'd1;

  // PMEM model; ld_* lets the bench preload entries through the same process.
  logic [W-1:0]  pmem [0:511];
  logic          ld_vld = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [W-1:0]  ld_dat = '0;

  always @(posedge clk) begin
    if (ld_vld) pmem[ld_addr] <= ld_dat;
    else if (!mem_cen && !mem_wen) pmem[mem_addr] <= mem_d;
    if (!mem_cen && mem_wen) mem_q <= pmem[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Protocol monitor: pop/access counts and read->write pairing.
  int            n_pop = 0;
  int            n_rd = 0;
  int            n_wr = 0;
  int            n_viol = 0;
  logic          prev_rd = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(negedge clk) begin
    if (ofifo_rd) n_pop++;
    if (ofifo_rd && !ofifo_valid) n_viol++;
    if (!mem_cen && mem_wen) n_rd++;
    if (!mem_cen && !mem_wen) n_wr++;
    if (!reset && prev_rd && !(!mem_cen && !mem_wen && mem_addr == prev_addr)) n_viol++;
    prev_rd   = !mem_cen && mem_wen;
    prev_addr = mem_addr;
  end

  function automatic logic [W-1:0] mk(input int l0, input int l1, input int l2, input int rest);
    logic [W-1:0] r;
    for (int k = 0; k < COL; k++) r[k*BW +: BW] = 16'(rest);
    r[0 +: BW]    = 16'(l0);
    r[BW +: BW]   = 16'(l1);
    r[2*BW +: BW] = 16'(l2);
    return r;
  endfunction

  task automatic push(input logic [W-1:0] row);
    fifo_mem[fifo_wr] = row;
    fifo_wr = fifo_wr + 8'd1;
  endtask

  task automatic preload(input logic [AW-1:0] addr, input logic [W-1:0] dat, input int n);
    for (int i = 0; i < n; i++) begin
      ld_vld  = 1'b1;
      ld_addr = addr + AW'(i);
      ld_dat  = dat;
      @(negedge clk); #1;
    end
    ld_vld = 1'b0;
  endtask

  // Pulses start, scrambles the latched inputs afterwards and re-pulses start mid-pass.
  task automatic run_pass(input logic fp, input logic re, input logic [AW-1:0] base,
                          input int max_cyc, output int lat, output logic busy_ok);
    int c0;
    start = 1'b1; first_pass = fp; relu_en = re; base_addr = base; c0 = cyc;
    @(negedge clk); #1;
    start = 1'b0; first_pass = ~fp; relu_en = ~re; base_addr = ~base;
    lat = -1; busy_ok = 1'b1;
    for (int i = 1; i < max_cyc; i++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      start = (i == 3);
      if (done === 1'b1) begin
        lat = cyc - c0;
        break;
      end
      @(negedge clk); #1;
    end
    start = 1'b0;
    @(negedge clk); #1;
    if (busy !== 1'b0 || done !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({ofifo_rd, mem_cen, mem_wen, busy, done} !== 5'b01100) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 01100", {ofifo_rd, mem_cen, mem_wen, busy, done});
    end
    checks++;
    if (mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_addr: got %0d want 0", mem_addr);
    end
    checks++;
    if (mem_d !== '0) begin
      errors++;
      $display("FAIL reset_d: got %h want 0", mem_d);
    end
    reset = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_first_pass;
    int lat, p0, r0, w0, v0, bad;
    logic bok;
    for (int i = 0; i < NPIX; i++) push(mk(i, i, i, i));
    p0 = n_pop; r0 = n_rd; w0 = n_wr; v0 = n_viol;
    run_pass(1'b1, 1'b0, 9'd0, 60, lat, bok);
    checks++;
    if (lat !== 17) begin errors++; $display("FAIL first_latency: got %0d want 17", lat); end
    checks++;
    if (!bok) begin errors++; $display("FAIL first_busy: got %0d want 1", bok); end
    checks++;
    if (n_pop - p0 !== 16) begin errors++; $display("FAIL first_pops: got %0d want 16", n_pop - p0); end
    checks++;
    if (n_rd - r0 !== 0) begin errors++; $display("FAIL first_reads: got %0d want 0", n_rd - r0); end
    checks++;
    if (n_wr - w0 !== 16) begin errors++; $display("FAIL first_writes: got %0d want 16", n_wr - w0); end
    checks++;
    if (n_viol - v0 !== 0) begin errors++; $display("FAIL first_protocol: got %0d want 0", n_viol - v0); end
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (pmem[i] !== mk(i, i, i, i)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL first_data: got %0d bad rows want 0 (row5=%h)", bad, pmem[5]); end
  endtask

  task automatic test_accum;
    int lat, p0, r0, w0, v0, bad;
    logic bok;
    preload(9'd0, mk(100, 100, 100, 100), NPIX);
    for (int i = 0; i < NPIX; i++) push(mk(5, 5, 5, 5));
    p0 = n_pop; r0 = n_rd; w0 = n_wr; v0 = n_viol;
    run_pass(1'b0, 1'b0, 9'd0, 80, lat, bok);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL accum_latency: got %0d want 33", lat); end
    checks++;
    if (!bok) begin errors++; $display("FAIL accum_busy: got %0d want 1", bok); end
    checks++;
    if (n_pop - p0 !== 16) begin errors++; $display("FAIL accum_pops: got %0d want 16", n_pop - p0); end
    checks++;
    if (n_rd - r0 !== 16 || n_wr - w0 !== 16) begin
      errors++; $display("FAIL accum_access: got rd=%0d wr=%0d want 16/16", n_rd - r0, n_wr - w0);
    end
    checks++;
    if (n_viol - v0 !== 0) begin errors++; $display("FAIL accum_protocol: got %0d want 0", n_viol - v0); end
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (pmem[i] !== mk(105, 105, 105, 105)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL accum_data: got %0d bad rows want 0 (row0=%h)", bad, pmem[0]); end
  endtask

  task automatic test_saturation;
    int lat, bad;
    logic bok;
    logic [W-1:0] r;
    preload(9'd32, mk(32000, -32000, -5, 0), NPIX);
    for (int i = 0; i < NPIX; i++) push(mk(1000, -1000, 3, 0));
    run_pass(1'b0, 1'b0, 9'd32, 80, lat, bok);
    r = pmem[32];
    checks++;
    if (r[0 +: BW] !== 16'h7FFF) begin errors++; $display("FAIL sat_pos: got %h want 7fff", r[0 +: BW]); end
    checks++;
    if (r[BW +: BW] !== 16'h8000) begin errors++; $display("FAIL sat_neg: got %h want 8000", r[BW +: BW]); end
    checks++;
    if (r[2*BW +: BW] !== 16'hFFFE) begin errors++; $display("FAIL sat_mixed: got %h want fffe", r[2*BW +: BW]); end
    bad = 0;
    for (int i = 32; i < 32 + NPIX; i++) if (pmem[i] !== mk(32767, -32768, -2, 0)) bad++;
    checks++;
    if (bad !== 0 || lat !== 33) begin errors++; $display("FAIL sat_rows: got %0d bad rows lat=%0d want 0/33", bad, lat); end
  endtask

  task automatic test_relu;
    int lat, bad;
    logic bok;
    logic [W-1:0] r;
    preload(9'd64, mk(-50, 50, -32768, 7), NPIX);
    for (int i = 0; i < NPIX; i++) push(mk(20, 20, -1, -100));
    run_pass(1'b0, 1'b1, 9'd64, 80, lat, bok);
    r = pmem[64];
    checks++;
    if (r[0 +: BW] !== 16'h0000) begin errors++; $display("FAIL relu_neg: got %h want 0000", r[0 +: BW]); end
    checks++;
    if (r[BW +: BW] !== 16'd70) begin errors++; $display("FAIL relu_pos: got %h want 0046", r[BW +: BW]); end
    checks++;
    if (r[2*BW +: BW] !== 16'h0000) begin errors++; $display("FAIL relu_sat: got %h want 0000", r[2*BW +: BW]); end
    bad = 0;
    for (int i = 64; i < 64 + NPIX; i++) if (pmem[i] !== mk(0, 70, 0, 0)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL relu_rows: got %0d bad rows want 0", bad); end
    for (int i = 0; i < NPIX; i++) push(mk(-7, 9, -32768, 3));
    run_pass(1'b1, 1'b1, 9'd80, 60, lat, bok);
    bad = 0;
    for (int i = 80; i < 80 + NPIX; i++) if (pmem[i] !== mk(0, 9, 0, 3)) bad++;
    checks++;
    if (bad !== 0 || lat !== 17) begin errors++; $display("FAIL relu_first: got %0d bad rows lat=%0d want 0/17", bad, lat); end
  endtask

  task automatic test_stall;
    int c0, p0, v0, lat, bad, sbad;
    logic acc_ok;
    preload(9'd96, mk(10, 10, 10, 10), NPIX);
    for (int i = 0; i < 4; i++) push(mk(i, i, i, i));
    p0 = n_pop; v0 = n_viol;
    start = 1'b1; first_pass = 1'b0; relu_en = 1'b0; base_addr = 9'd96; c0 = cyc;
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 40 && (n_pop - p0) < 4; i++) begin
      @(negedge clk); #1;
    end
    @(negedge clk); #1;
    acc_ok = (mem_cen === 1'b0) && (mem_wen === 1'b0) && (mem_addr === 9'd99);
    checks++;
    if (!acc_ok) begin
      errors++; $display("FAIL stall_accum_write: got cen=%b wen=%b addr=%0d want 0/0/99", mem_cen, mem_wen, mem_addr);
    end
    sbad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (ofifo_rd !== 1'b0 || mem_cen !== 1'b1) sbad++;
    end
    checks++;
    if (sbad !== 0) begin errors++; $display("FAIL stall_idle: got %0d active cycles want 0", sbad); end
    @(posedge clk); #1;
    for (int i = 4; i < NPIX; i++) push(mk(i, i, i, i));
    lat = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk); #1;
      if (done === 1'b1) begin
        lat = cyc - c0;
        break;
      end
    end
    checks++;
    if (lat !== 36) begin errors++; $display("FAIL stall_latency: got %0d want 36", lat); end
    checks++;
    if (n_pop - p0 !== 16 || n_viol - v0 !== 0) begin
      errors++; $display("FAIL stall_protocol: got pops=%0d viol=%0d want 16/0", n_pop - p0, n_viol - v0);
    end
    bad = 0;
    for (int i = 0; i < NPIX; i++) if (pmem[96 + i] !== mk(10 + i, 10 + i, 10 + i, 10 + i)) bad++;
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL stall_data: got %0d bad rows want 0", bad); end
    @(negedge clk); #1;
  endtask

  task automatic test_reset_wrap;
    int w0, lat, idle_bad;
    logic bok;
    preload(9'd128, mk(999, 999, 999, 999), NPIX);
    for (int i = 0; i < 6; i++) push(mk(50 + i, 50 + i, 50 + i, 50 + i));
    w0 = n_wr;
    start = 1'b1; first_pass = 1'b1; relu_en = 1'b0; base_addr = 9'd128;
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 40 && (n_wr - w0) < 6; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({ofifo_rd, mem_cen, mem_wen, busy, done} !== 5'b01100 || mem_addr !== '0 || mem_d !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got ctrl=%b addr=%0d d=%h want 01100/0/0",
               {ofifo_rd, mem_cen, mem_wen, busy, done}, mem_addr, mem_d);
    end
    checks++;
    if (pmem[133] !== mk(55, 55, 55, 55) || pmem[134] !== mk(999, 999, 999, 999)) begin
      errors++; $display("FAIL midreset_pmem: got p133=%h p134=%h", pmem[133], pmem[134]);
    end
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < NPIX; i++) push(mk(200 + i, 200 + i, 200 + i, 200 + i));
    idle_bad = 0;
    repeat (3) begin
      @(negedge clk); #1;
      if (ofifo_rd !== 1'b0 || busy !== 1'b0 || mem_cen !== 1'b1) idle_bad++;
    end
    checks++;
    if (idle_bad !== 0) begin errors++; $display("FAIL post_reset_idle: got %0d active cycles want 0", idle_bad); end
    run_pass(1'b1, 1'b0, 9'd510, 60, lat, bok);
    checks++;
    if (lat !== 17 || !bok) begin errors++; $display("FAIL wrap_latency: got %0d busy_ok=%0d want 17/1", lat, bok); end
    checks++;
    if (pmem[510] !== mk(200, 200, 200, 200) || pmem[511] !== mk(201, 201, 201, 201)) begin
      errors++; $display("FAIL wrap_top: got p510=%h p511=%h", pmem[510], pmem[511]);
    end
    checks++;
    if (pmem[0] !== mk(202, 202, 202, 202) || pmem[13] !== mk(215, 215, 215, 215)) begin
      errors++; $display("FAIL wrap_low: got p0=%h p13=%h", pmem[0], pmem[13]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start = 1'b0; first_pass = 1'b0; relu_en = 1'b0; base_addr = '0;
    test_reset();
    test_first_pass();
    test_accum();
    test_saturation();
    test_relu();
    test_stall();
    test_reset_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
